wave_pwm_dac: RTL and testbench
===============================

Name: wave_pwm_dac

Overview:
- Output stage directly downstream of the waveform generator.
- Consumes the selected 8-bit sample stream (`dataOut` of the generator) and converts it into a single-bit PWM signal for the board's RC-filter DAC.
- Applies a selectable amplitude attenuation and emits a one-cycle sample strobe at each PWM frame boundary. Upstream logic or the testbench uses this strobe to align sample changes.

Parameters:
- WIDTH, 8, sample width and PWM counter width; frame length is 2^WIDTH cycles.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 forces the reset state immediately; release is synchronous to clk.
- en  input  1  run enable; 0 parks the block in IDLE.
- dataIn  input  WIDTH  unsigned sample from the waveform generator.
- ampSel  input  3  amplitude gain, (ampSel+1)/8; 3'b111 = unity.
- pwmOut  output  1  PWM output, registered.
- sampleTick  output  1  one-cycle pulse; high in the first cycle of every frame, when the new duty takes effect.
- duty  output  WIDTH  currently applied duty value, registered (debug/verification).

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, duty=0, pwmOut=0, sampleTick=0.
- Scaling: scaled = (dataIn * (ampSel+1)) >> 3.
  - The product is computed at WIDTH+3 bits; the result always fits in WIDTH bits (max 255*8>>3 = 255).
  - Truncation only, no rounding.
- State machine, two states (IDLE, RUN):
  - IDLE, en=0: hold cnt=0, pwmOut=0, sampleTick=0; duty holds its last value.
  - IDLE, en=1: duty<=scaled(dataIn), cnt<=0, sampleTick<=1, pwmOut<=(scaled!=0), go RUN. This edge starts frame cycle 0.
  - RUN, en=1, cnt<MAX (MAX=2^WIDTH-1): cnt<=cnt+1, pwmOut<=((cnt+1)<duty), sampleTick<=0.
  - RUN, en=1, cnt==MAX: wrap cnt<=0, duty<=scaled(dataIn) sampled this cycle, sampleTick<=1, pwmOut<=(scaled!=0).
  - RUN, en=0: go IDLE on the same edge; cnt<=0, pwmOut<=0, sampleTick<=0. This aborts the current frame and applies no partial-frame correction.
- Per-frame timing: pwmOut is high exactly in frame cycles 0..duty-1, i.e. duty of 2^WIDTH cycles.
  - duty=0: never high.
  - duty=255: high 255/256; low only in cycle 255.
- Duty is updated only at frame boundaries. Changes on dataIn or ampSel mid-frame have no effect until the next wrap.
  - Only the value present in the cnt==MAX cycle (or the IDLE->RUN cycle) is used.
- Latency: a sample presented in the wrap cycle appears on pwmOut and duty in the next cycle (1 clk).
- sampleTick: high for exactly one cycle per frame, period 2^WIDTH cycles in steady state. It is never high in IDLE.
- Simultaneous events:
  - en falling in the wrap cycle: IDLE wins; no tick, duty not updated.
  - rst asserted at any time: immediate reset values regardless of state; when rst releases with en=1, the IDLE->RUN start occurs on the first clk edge.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: drive rst=0 mid-frame with en=1, dataIn=200 -> pwmOut, sampleTick, duty go 0 asynchronously without waiting for clk. After release, the first edge gives sampleTick=1, duty=175 (ampSel=6: 200*7>>3).
- Unity gain, dataIn=64, ampSel=7, en=1 for 3 frames -> duty=64; pwmOut high exactly 64 cycles then low 192 per frame; sampleTick every 256 cycles, coincident with the pwmOut rising edge.
- Extremes: dataIn=0 -> pwmOut constantly 0 with ticks still present. dataIn=255, ampSel=7 -> pwmOut low only in cnt=255. dataIn=255, ampSel=0 -> duty=31.
- Mid-frame change: duty=100 running; change dataIn to 10 at cnt=50 -> the current frame stays 100 high cycles; the next frame is 10 high cycles.
- Enable abort: en drops at cnt=30 with duty=100 -> next edge pwmOut=0, cnt=0, no tick. en re-raised -> tick on the first edge, and the new duty is captured from dataIn at that edge.
- Wrap-cycle collision: en drops exactly at cnt=255 with dataIn changed to 77 -> no sampleTick, duty keeps its old value, state IDLE.

Source files
------------

// File: rtl/wave_pwm_dac.sv
// PWM output stage for the RC-filter DAC: scales each sample by (ampSel+1)/8 and
// emits one PWM frame of 2^WIDTH cycles per sample, with a strobe on each frame start.
module wave_pwm_dac #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] dataIn,
    input  logic [2:0]       ampSel,
    output logic             pwmOut,
    output logic             sampleTick,
    output logic [WIDTH-1:0] duty,
    output logic             stateDbg,
    output logic [WIDTH-1:0] cntDbg
);

    // Handshake: none. Samples are not acknowledged; the producer watches
    // sampleTick and only the value present in the wrap cycle (cnt==MAX) or
    // in the IDLE->RUN cycle is captured.

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cntNext;
    logic [3:0]       gain;
    logic [WIDTH+2:0] product;
    logic [WIDTH-1:0] scaled;

    // Product of a WIDTH-bit sample and a gain of at most 8 fits in WIDTH+3 bits;
    // dropping the low three bits is the divide by 8 (truncating).
    always_comb begin
        gain    = {1'b0, ampSel} + 4'd1;
        product = {3'b000, dataIn} * {{(WIDTH-1){1'b0}}, gain};
        scaled  = product[WIDTH+2:3];
        cntNext = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            duty       <= '0;
            pwmOut     <= 1'b0;
            sampleTick <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en) begin
                        duty       <= scaled;
                        sampleTick <= 1'b1;
                        pwmOut     <= (scaled != '0);
                        state      <= RUN;
                    end else begin
                        sampleTick <= 1'b0;
                        pwmOut     <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        // Abort wins over a wrap in the same cycle: no tick, duty kept.
                        state      <= IDLE;
                        cnt        <= '0;
                        pwmOut     <= 1'b0;
                        sampleTick <= 1'b0;
                    end else if (cnt == MAX) begin
                        cnt        <= '0;
                        duty       <= scaled;
                        sampleTick <= 1'b1;
                        pwmOut     <= (scaled != '0);
                    end else begin
                        cnt        <= cntNext;
                        pwmOut     <= (cntNext < duty);
                        sampleTick <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    pwmOut     <= 1'b0;
                    sampleTick <= 1'b0;
                end
            endcase
        end
    end

    assign stateDbg = state;
    assign cntDbg   = cnt;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Directed bench for wave_pwm_dac: reset, gain scaling, frame timing, mid-frame
// changes, enable abort and the wrap/disable collision.
module tb_wave_pwm_dac;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] dataIn = 8'd0;
    logic [2:0] ampSel = 3'd7;
    logic       pwmOut;
    logic       sampleTick;
    logic [7:0] duty;
    logic       stateDbg;
    logic [7:0] cntDbg;

    int total = 0;
    int bad = 0;

    wave_pwm_dac #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .dataIn(dataIn),
        .ampSel(ampSel),
        .pwmOut(pwmOut),
        .sampleTick(sampleTick),
        .duty(duty),
        .stateDbg(stateDbg),
        .cntDbg(cntDbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Park in IDLE for one edge, then start a fresh frame; returns in frame cycle 0.
    task automatic restart(input logic [7:0] d, input logic [2:0] a);
        en = 1'b0;
        step();
        dataIn = d;
        ampSel = a;
        en = 1'b1;
        step();
    endtask

    // Check one full frame starting at cycle 0; optionally change dataIn after cycle changeAt.
    task automatic run_frame(input int expDuty, input int changeAt, input logic [7:0] newData,
                             input string name);
        int errs;
        int highs;
        logic [7:0] expD;
        errs = 0;
        highs = 0;
        expD = expDuty[7:0];
        for (int k = 0; k < 256; k++) begin
            if (pwmOut !== 1'(k < expDuty)) errs++;
            if (sampleTick !== 1'(k == 0)) errs++;
            if (duty !== expD) errs++;
            if (pwmOut === 1'b1) highs++;
            if (k == changeAt) dataIn = newData;
            step();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s pattern: errors=%0d required=0", name, errs);
        end
        total++;
        if (highs != expDuty) begin
            bad++;
            $display("FAIL %s highCount: got=%0d required=%0d", name, highs, expDuty);
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (pwmOut !== 1'b0) begin bad++; $display("FAIL reset pwmOut: got=%b required=0", pwmOut); end
        total++; if (sampleTick !== 1'b0) begin bad++; $display("FAIL reset sampleTick: got=%b required=0", sampleTick); end
        total++; if (duty !== 8'd0) begin bad++; $display("FAIL reset duty: got=%0d required=0", duty); end
        total++; if (stateDbg !== 1'b0) begin bad++; $display("FAIL reset state: got=%b required=0", stateDbg); end
        en = 1'b1;
        dataIn = 8'd200;
        ampSel = 3'd6;
        step();
        rst = 1'b1;
        step();
        total++; if (sampleTick !== 1'b1 || duty !== 8'd175) begin
            bad++; $display("FAIL start tick/duty: got=%b/%0d required=1/175", sampleTick, duty);
        end
        repeat (40) step();
        total++; if (pwmOut !== 1'b1 || cntDbg !== 8'd40) begin
            bad++; $display("FAIL midframe pwm/cnt: got=%b/%0d required=1/40", pwmOut, cntDbg);
        end
        #2 rst = 1'b0;
        #1;
        total++; if (pwmOut !== 1'b0 || sampleTick !== 1'b0 || duty !== 8'd0) begin
            bad++; $display("FAIL async reset: got pwm=%b tick=%b duty=%0d required 0/0/0", pwmOut, sampleTick, duty);
        end
        total++; if (cntDbg !== 8'd0 || stateDbg !== 1'b0) begin
            bad++; $display("FAIL async reset cnt/state: got=%0d/%b required=0/0", cntDbg, stateDbg);
        end
        #2 rst = 1'b1;
        step();
        total++; if (sampleTick !== 1'b1 || duty !== 8'd175 || pwmOut !== 1'b1 || stateDbg !== 1'b1) begin
            bad++; $display("FAIL release start: got tick=%b duty=%0d pwm=%b state=%b required 1/175/1/1",
                            sampleTick, duty, pwmOut, stateDbg);
        end
    endtask

    task automatic test_unity();
        restart(8'd64, 3'd7);
        run_frame(64, -1, 8'd0, "unity1");
        run_frame(64, -1, 8'd0, "unity2");
        run_frame(64, -1, 8'd0, "unity3");
    endtask

    task automatic test_extremes();
        restart(8'd0, 3'd7);
        run_frame(0, -1, 8'd0, "zero1");
        run_frame(0, -1, 8'd0, "zero2");
        restart(8'd255, 3'd7);
        run_frame(255, -1, 8'd0, "full");
        restart(8'd255, 3'd0);
        run_frame(31, -1, 8'd0, "minGain");
        restart(8'd100, 3'd3);
        run_frame(50, -1, 8'd0, "halfGain");
    endtask

    task automatic test_mid_frame();
        restart(8'd100, 3'd7);
        run_frame(100, 50, 8'd10, "midChangeCur");
        run_frame(10, -1, 8'd0, "midChangeNext");
    endtask

    task automatic test_abort();
        restart(8'd100, 3'd7);
        repeat (30) step();
        en = 1'b0;
        step();
        total++; if (pwmOut !== 1'b0 || cntDbg !== 8'd0 || sampleTick !== 1'b0) begin
            bad++; $display("FAIL abort: got pwm=%b cnt=%0d tick=%b required 0/0/0", pwmOut, cntDbg, sampleTick);
        end
        total++; if (duty !== 8'd100 || stateDbg !== 1'b0) begin
            bad++; $display("FAIL abort duty/state: got=%0d/%b required=100/0", duty, stateDbg);
        end
        step();
        total++; if (sampleTick !== 1'b0 || pwmOut !== 1'b0) begin
            bad++; $display("FAIL idle hold: got tick=%b pwm=%b required 0/0", sampleTick, pwmOut);
        end
        dataIn = 8'd40;
        en = 1'b1;
        step();
        run_frame(40, -1, 8'd0, "reenable");
    endtask

    task automatic test_collision();
        restart(8'd100, 3'd7);
        repeat (255) step();
        total++; if (cntDbg !== 8'd255) begin
            bad++; $display("FAIL wrap position: got cnt=%0d required=255", cntDbg);
        end
        en = 1'b0;
        dataIn = 8'd77;
        step();
        total++; if (sampleTick !== 1'b0 || duty !== 8'd100 || stateDbg !== 1'b0 || pwmOut !== 1'b0) begin
            bad++; $display("FAIL collision: got tick=%b duty=%0d state=%b pwm=%b required 0/100/0/0",
                            sampleTick, duty, stateDbg, pwmOut);
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_extremes();
        test_mid_frame();
        test_abort();
        test_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
